// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: arbitrates entry/exit requests onto one gate sequencer and owns the 8-slot occupancy map.
// Define PARK_STATS_EN to add saturating entry/timeout counters with a synchronous stats clear.
module parking_gate_ctrl #(
    parameter int NUM_SLOTS   = 8,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CLOSE_CYC   = 16,
    parameter int TW          = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_entry_req,
    input  logic                 i_exit_req,
    input  logic [2:0]           i_exit_slot,
    input  logic                 i_pass_sensor,
`ifdef PARK_STATS_EN
    input  logic                 i_stats_clr,
    output logic [15:0]          o_total_entries,
    output logic [7:0]           o_total_timeouts,
`endif
    output logic [NUM_SLOTS-1:0] o_occupancy,
    output logic [3:0]           o_car_count,
    output logic                 o_full,
    output logic                 o_entry_gate_open,
    output logic                 o_exit_gate_open,
    output logic [2:0]           o_assigned_slot,
    output logic                 o_assigned_valid,
    output logic                 o_busy,
    output logic                 o_exit_err
);
    typedef enum logic [1:0] {S_IDLE, S_ENTRY_OPEN, S_EXIT_OPEN, S_CLOSING} state_t;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] CL_LAST = TW'(CLOSE_CYC - 1);

    state_t               r_state, w_next;
    logic [TW-1:0]        r_timer, w_timer_next;
    logic [NUM_SLOTS-1:0] r_occ, w_occ_next;
    logic [3:0]           r_count;
    logic                 r_full;
    logic                 r_entry_d, r_exit_d, r_pass_d;
    logic                 r_entry_pend, r_exit_pend;
    logic [2:0]           r_exit_idx, r_exit_cur;
    logic [2:0]           r_slot, w_slot_next, w_free_slot;
    logic                 r_slot_valid, w_slot_valid;
    logic                 r_exit_err, w_exit_err;
    logic                 r_entry_gate, r_exit_gate;
    logic                 w_entry_clr, w_exit_clr;
    logic                 w_entry_rise, w_exit_rise, w_pass_fall;
    logic                 w_open, w_timeout, w_entry_done, w_exit_done;

    assign w_entry_rise = i_entry_req & ~r_entry_d;
    assign w_exit_rise  = i_exit_req & ~r_exit_d;
    assign w_pass_fall  = r_pass_d & ~i_pass_sensor;
    assign w_open       = (r_state == S_ENTRY_OPEN) || (r_state == S_EXIT_OPEN);
    // A pass completing on the timeout cycle wins over the abort.
    assign w_timeout    = w_open & ~w_pass_fall & (r_timer == TO_LAST);
    assign w_entry_done = (r_state == S_ENTRY_OPEN) & w_pass_fall;
    assign w_exit_done  = (r_state == S_EXIT_OPEN) & w_pass_fall;

    always_comb begin
        w_free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!r_occ[i]) w_free_slot = 3'(i);
    end

    always_comb begin
        w_next       = r_state;
        w_timer_next = r_timer + 1'b1;
        w_occ_next   = r_occ;
        w_slot_next  = r_slot;
        w_slot_valid = 1'b0;
        w_exit_err   = 1'b0;
        w_entry_clr  = 1'b0;
        w_exit_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_next = '0;
                if (r_exit_pend && !r_occ[r_exit_idx]) begin
                    w_exit_err = 1'b1;
                    w_exit_clr = 1'b1;
                end else if (r_exit_pend) begin
                    w_exit_clr = 1'b1;
                    w_next     = S_EXIT_OPEN;
                end else if (r_entry_pend && !r_full) begin
                    w_slot_next  = w_free_slot;
                    w_slot_valid = 1'b1;
                    w_entry_clr  = 1'b1;
                    w_next       = S_ENTRY_OPEN;
                end
            end
            S_ENTRY_OPEN, S_EXIT_OPEN: begin
                if (w_entry_done) w_occ_next[r_slot] = 1'b1;
                if (w_exit_done) w_occ_next[r_exit_cur] = 1'b0;
                if (w_pass_fall || w_timeout) begin
                    w_next       = S_CLOSING;
                    w_timer_next = '0;
                end
            end
            S_CLOSING: begin
                if (r_timer == CL_LAST) begin
                    w_next       = S_IDLE;
                    w_timer_next = '0;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_occ        <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_entry_d    <= 1'b0;
            r_exit_d     <= 1'b0;
            r_pass_d     <= 1'b0;
            r_entry_pend <= 1'b0;
            r_exit_pend  <= 1'b0;
            r_exit_idx   <= '0;
            r_exit_cur   <= '0;
            r_slot       <= '0;
            r_slot_valid <= 1'b0;
            r_exit_err   <= 1'b0;
            r_entry_gate <= 1'b0;
            r_exit_gate  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_timer      <= w_timer_next;
            r_occ        <= w_occ_next;
            r_count      <= 4'($countones(r_occ));
            r_full       <= ($countones(r_occ) == NUM_SLOTS);
            r_entry_d    <= i_entry_req;
            r_exit_d     <= i_exit_req;
            r_pass_d     <= i_pass_sensor;
            // An edge arriving while the flag is already pending is absorbed.
            r_entry_pend <= (r_entry_pend & ~w_entry_clr) | (w_entry_rise & ~r_entry_pend);
            r_exit_pend  <= (r_exit_pend & ~w_exit_clr) | (w_exit_rise & ~r_exit_pend);
            if (w_exit_rise && !r_exit_pend) r_exit_idx <= i_exit_slot;
            if (w_exit_clr) r_exit_cur <= r_exit_idx;
            r_slot       <= w_slot_next;
            r_slot_valid <= w_slot_valid;
            r_exit_err   <= w_exit_err;
            r_entry_gate <= (w_next == S_ENTRY_OPEN);
            r_exit_gate  <= (w_next == S_EXIT_OPEN);
        end
    end

`ifdef PARK_STATS_EN
    logic [15:0] r_tot_entries;
    logic [7:0]  r_tot_timeouts;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_stats_clr) begin
            r_tot_entries  <= '0;
            r_tot_timeouts <= '0;
        end else begin
            if (w_entry_done && r_tot_entries != '1) r_tot_entries <= r_tot_entries + 1'b1;
            if (w_timeout && r_tot_timeouts != '1) r_tot_timeouts <= r_tot_timeouts + 1'b1;
        end
    end

    assign o_total_entries  = r_tot_entries;
    assign o_total_timeouts = r_tot_timeouts;
`endif

    assign o_occupancy       = r_occ;
    assign o_car_count       = r_count;
    assign o_full            = r_full;
    assign o_entry_gate_open = r_entry_gate;
    assign o_exit_gate_open  = r_exit_gate;
    assign o_assigned_slot   = r_slot;
    assign o_assigned_valid  = r_slot_valid;
    assign o_busy            = (r_state != S_IDLE);
    assign o_exit_err        = r_exit_err;
endmodule
